// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: operand stream and result stream of the MAC sequencer
interface dsp_mac_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  modport slave (input in_valid, in_a, in_b, res_ready, output in_ready, res_valid, res_data);
  modport master (output in_valid, in_a, in_b, res_ready, input in_ready, res_valid, res_data);
endinterface

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds a DSP48A1 MAC with operands and pipeline-aligned OPMODE, returns the dot product
module dsp_mac_sequencer #(
  parameter int LW      = 8,
  parameter int OPM_DLY = 1,
  parameter int P_LAT   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] cfg_len,
  dsp_mac_sequencer_if.slave s,
  output logic [17:0]   dsp_a,
  output logic [17:0]   dsp_b,
  output logic [7:0]    dsp_opmode,
  input  logic [47:0]   dsp_p,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [LW-1:0] len, cnt;
  logic [7:0]    tag [OPM_DLY+1];
  logic [P_LAT:0] last;
  logic acc, fin, go;
  assign go  = state == IDLE && start && cfg_len != '0;
  assign acc = s.in_valid && s.in_ready;
  assign fin = acc && cnt == len - 1'b1;
  assign dsp_opmode = tag[OPM_DLY];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = go ? RUN : IDLE;
      RUN:   state_nx = fin ? DRAIN : RUN;
      DRAIN: state_nx = last[P_LAT] ? DONE : DRAIN;
      DONE:  state_nx = s.res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    s.in_ready  = state == RUN;
    s.res_valid = state == DONE;
    busy        = state != IDLE;
  end
  // tag[0] and last[0] describe the cycle in which the registered pair sits on dsp_a/dsp_b
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len        <= '0;
      cnt        <= '0;
      dsp_a      <= '0;
      dsp_b      <= '0;
      last       <= '0;
      s.res_data <= '0;
      for (int i = 0; i <= OPM_DLY; i++) tag[i] <= '0;
    end else begin
      if (go) begin
        len <= cfg_len;
        cnt <= '0;
      end
      if (acc) begin
        cnt   <= cnt + 1'b1;
        dsp_a <= s.in_a;
        dsp_b <= s.in_b;
      end
      tag[0] <= acc ? (cnt == '0 ? 8'h01 : 8'h09) : (state == RUN || state == DRAIN) ? 8'h08 : 8'h00;
      for (int i = 1; i <= OPM_DLY; i++) tag[i] <= tag[i-1];
      last <= {last[P_LAT-1:0], fin};
      if (state == DRAIN && last[P_LAT]) s.res_data <= dsp_p;
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: scoreboard bench with a behavioural DSP48A1 MAC slice model
module tb_dsp_mac_sequencer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [7:0]  cfg_len = 0;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        busy;
  dsp_mac_sequencer_if bus();
  dsp_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .s(bus),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_p(dsp_p), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // slice: A1/B1 regs, M reg, OPMODE reg, P reg
  logic [17:0] a1 = 0, b1 = 0;
  logic [35:0] m = 0;
  logic [7:0]  opr = 0;
  logic [47:0] p = 0;
  always @(posedge clk) begin
    a1  <= dsp_a;
    b1  <= dsp_b;
    m   <= a1 * b1;
    opr <= dsp_opmode;
    p   <= (opr[1:0] == 2'b01 ? {12'b0, m} : 48'b0) + (opr[3:2] == 2'b10 ? p : 48'b0);
  end
  assign dsp_p = p;
  int n_cmp = 0, n_bad = 0;
  int last_acc = 0;
  logic [47:0] exp_q [$];
  logic [7:0]  opm_log [0:4095];
  logic        rv_q = 0;
  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask
  always @(negedge clk) begin
    opm_log[cyc % 4096] = dsp_opmode;
    if (rst_n) begin
      if (bus.res_valid && !rv_q) chk("latency", 48'(cyc - last_acc), 48'd5);
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: actual=%0h required=none", bus.res_data);
        end else chk("result", bus.res_data, exp_q.pop_front());
      end
    end
    rv_q = bus.res_valid;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_job(input logic [7:0] len, input logic [47:0] expv, input bit push);
    start = 1;
    cfg_len = len;
    if (push) exp_q.push_back(expv);
    tick();
    start = 0;
  endtask
  task automatic send(input logic [17:0] a, input logic [17:0] b, input int gap);
    bit done = 0;
    bus.in_valid = 1;
    bus.in_a = a;
    bus.in_b = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        last_acc = cyc;
        done = 1;
      end
      tick();
    end
    if (!done) chk("accept_timeout", 48'd0, 48'd1);
    bus.in_valid = 0;
    repeat (gap) tick();
  endtask
  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = !busy && exp_q.size() == 0;
    end
    if (!done) chk("idle_timeout", 48'd0, 48'd1);
    tick();
  endtask
  int c0;
  bit ok;
  initial begin
    bus.in_valid = 0;
    bus.in_a = 0;
    bus.in_b = 0;
    bus.res_ready = 1;
    repeat (3) tick();
    chk("rst_busy", {47'd0, busy}, 48'd0);
    chk("rst_opmode", {40'd0, dsp_opmode}, 48'd0);
    chk("rst_res_valid", {47'd0, bus.res_valid}, 48'd0);
    chk("rst_res_data", bus.res_data, 48'd0);
    rst_n = 1;
    tick();
    start_job(8'd0, 48'd0, 0);
    @(negedge clk);
    chk("len0_ignored", {47'd0, busy}, 48'd0);
    tick();
    // back-to-back
    start_job(8'd3, 48'd68, 1);
    send(18'd2, 18'd3, 0);
    c0 = last_acc;
    send(18'd4, 18'd5, 0);
    send(18'd6, 18'd7, 0);
    wait_idle();
    chk("opm_first", {40'd0, opm_log[(c0+2)%4096]}, 48'h01);
    chk("opm_second", {40'd0, opm_log[(c0+3)%4096]}, 48'h09);
    chk("opm_third", {40'd0, opm_log[(c0+4)%4096]}, 48'h09);
    chk("opm_drain", {40'd0, opm_log[(c0+5)%4096]}, 48'h08);
    // gaps between pairs
    start_job(8'd3, 48'd68, 1);
    send(18'd2, 18'd3, 2);
    c0 = last_acc;
    send(18'd4, 18'd5, 2);
    send(18'd6, 18'd7, 0);
    wait_idle();
    chk("opm_gap_first", {40'd0, opm_log[(c0+2)%4096]}, 48'h01);
    chk("opm_gap_bubble", {40'd0, opm_log[(c0+3)%4096]}, 48'h08);
    chk("opm_gap_second", {40'd0, opm_log[(c0+5)%4096]}, 48'h09);
    // full-scale operands
    start_job(8'd4, 48'h3F_FFE0_0004, 1);
    repeat (4) send(18'h3FFFF, 18'h3FFFF, 0);
    wait_idle();
    // two jobs, no carry-over
    start_job(8'd1, 48'd100, 1);
    send(18'd10, 18'd10, 0);
    wait_idle();
    start_job(8'd2, 48'd2, 1);
    send(18'd1, 18'd1, 0);
    send(18'd1, 18'd1, 0);
    wait_idle();
    // result held under backpressure
    bus.res_ready = 0;
    start_job(8'd3, 48'd68, 1);
    send(18'd2, 18'd3, 0);
    send(18'd4, 18'd5, 0);
    send(18'd6, 18'd7, 0);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.res_valid;
    end
    if (!ok) chk("res_valid_timeout", 48'd0, 48'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      cfg_len = 8'd5;
      @(negedge clk);
      chk("hold_valid", {47'd0, bus.res_valid}, 48'd1);
      chk("hold_data", bus.res_data, 48'd68);
      chk("hold_in_ready", {47'd0, bus.in_ready}, 48'd0);
      tick();
    end
    start = 0;
    bus.res_ready = 1;
    tick();
    @(negedge clk);
    chk("released_idle", {47'd0, busy}, 48'd0);
    chk("queue_drained", 48'(exp_q.size()), 48'd0);
    tick();
    // reset mid-job
    start_job(8'd4, 48'd0, 0);
    send(18'd5, 18'd6, 0);
    send(18'd7, 18'd8, 0);
    rst_n = 0;
    #1;
    chk("abort_busy", {47'd0, busy}, 48'd0);
    chk("abort_dsp_a", {30'd0, dsp_a}, 48'd0);
    chk("abort_opmode", {40'd0, dsp_opmode}, 48'd0);
    chk("abort_in_ready", {47'd0, bus.in_ready}, 48'd0);
    repeat (2) tick();
    rst_n = 1;
    repeat (8) tick();
    chk("abort_no_result", {47'd0, bus.res_valid}, 48'd0);
    start_job(8'd1, 48'd9, 1);
    send(18'd3, 18'd3, 0);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
